// File: rtl/quasi_irq_pkg.sv
// Shared definitions for the core-local interrupt gate: cause codes, mip/mie
// bit positions, request FSM encoding and the fixed-priority selector.
package quasi_irq_pkg;

    localparam logic [3:0] CAUSE_MSI = 4'd3;
    localparam logic [3:0] CAUSE_MTI = 4'd7;
    localparam logic [3:0] CAUSE_MEI = 4'd11;

    localparam int MSIP_BIT = 3;
    localparam int MTIP_BIT = 7;
    localparam int MEIP_BIT = 11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_BUSY = 2'd2
    } irq_state_e;

    // Only meaningful when at least one enable is set; MTI is the fallback.
    function automatic logic [3:0] pick_cause(input logic mei_en, input logic msi_en);
        if (mei_en) begin
            return CAUSE_MEI;
        end else if (msi_en) begin
            return CAUSE_MSI;
        end else begin
            return CAUSE_MTI;
        end
    endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// One external interrupt source: 2-flop synchroniser, delay flop for edge
// detection and the software-visible pending bit (edge-latched or level).
module irq_sync_edge
    import quasi_irq_pkg::*;
#(
    parameter logic EDGE = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic e_irq_i,
    input  logic ext_clr_i,
    output logic pend_o,
    output logic pend_d_o
);

    logic meta_q;
    logic sync_q;
    logic dly_q;
    logic pend_q;
    logic pend_d;

    // NOTE: every signal assigned in always_comb gets a value on every path, so no latch is inferred.
    always_comb begin
        pend_d = sync_q;
        if (EDGE) begin
            // A new rising edge outranks a clear arriving in the same cycle.
            pend_d = (sync_q & ~dly_q) | (pend_q & ~ext_clr_i);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            dly_q  <= 1'b0;
            pend_q <= 1'b0;
        end else begin
            meta_q <= e_irq_i;
            sync_q <= meta_q;
            dly_q  <= sync_q;
            pend_q <= pend_d;
        end
    end

    assign pend_o   = pend_q;
    assign pend_d_o = pend_d;

endmodule

// File: rtl/core_irq_gate.sv
// Core-local interrupt gate: builds the mip image, masks with mie/MIE, picks
// a fixed-priority cause and presents it to the CPU under req/ack/done.
module core_irq_gate
    import quasi_irq_pkg::*;
#(
    parameter int               N_EXT    = 4,
    parameter logic [N_EXT-1:0] EXT_EDGE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_irq,
    input  logic             t_irq,
    input  logic [N_EXT-1:0] e_irq,
    input  logic [N_EXT-1:0] ext_clr,
    input  logic             glb_ie,
    input  logic [31:0]      mie,
    input  logic             irq_ack,
    input  logic             irq_done,
    output logic [31:0]      mip,
    output logic [N_EXT-1:0] ext_pend,
    output logic             irq_req,
    output logic [3:0]       irq_cause
);

    logic [N_EXT-1:0] pend_d;
    logic             msip_q;
    logic             mtip_q;
    logic             meip_q;
    irq_state_e       state_q;
    logic             req_q;
    logic [3:0]       cause_q;
    logic [31:0]      en;

    for (genvar i = 0; i < N_EXT; i++) begin : g_ext
        irq_sync_edge #(
            .EDGE (EXT_EDGE[i])
        ) u_sync (
            .clk       (clk),
            .rst       (rst),
            .e_irq_i   (e_irq[i]),
            .ext_clr_i (ext_clr[i]),
            .pend_o    (ext_pend[i]),
            .pend_d_o  (pend_d[i])
        );
    end

    // MEIP is registered from the next-state pending vector so mip stays a pure flop output.
    always_ff @(posedge clk) begin
        if (rst) begin
            msip_q <= 1'b0;
            mtip_q <= 1'b0;
            meip_q <= 1'b0;
        end else begin
            msip_q <= s_irq;
            mtip_q <= t_irq;
            meip_q <= |pend_d;
        end
    end

    always_comb begin
        mip           = '0;
        mip[MSIP_BIT] = msip_q;
        mip[MTIP_BIT] = mtip_q;
        mip[MEIP_BIT] = meip_q;
    end

    assign en = mip & mie & {32{glb_ie}};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
            cause_q <= 4'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (en != 32'd0) begin
                        state_q <= ST_REQ;
                        req_q   <= 1'b1;
                        cause_q <= pick_cause(en[MEIP_BIT], en[MSIP_BIT]);
                    end
                end
                ST_REQ: begin
                    // The cause stays frozen; only ack or withdrawal of that cause leaves REQ.
                    if (irq_ack) begin
                        state_q <= ST_BUSY;
                        req_q   <= 1'b0;
                    end else if (!en[{1'b0, cause_q}]) begin
                        state_q <= ST_IDLE;
                        req_q   <= 1'b0;
                    end
                end
                ST_BUSY: begin
                    if (irq_done) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

    assign irq_req   = req_q;
    assign irq_cause = cause_q;

endmodule

// File: doc/core_irq_gate.md
# core_irq_gate

Sits directly downstream of the core-local interrupt controller and feeds the CPU trap logic. It registers the software (`s_irq`) and timer (`t_irq`) levels, and synchronises N external sources, each with per-source edge or level capture. It assembles a RISC-V `mip` image, applies `mie`/`mstatus.MIE` masking and fixed priority, and presents a single request with a stable cause code to the CPU under a req/ack/done handshake.

## Interface
- `N_EXT`, 4: number of external interrupt sources (1..16).
- `EXT_EDGE`, 4'b0000: per-source mode mask; 1 = rising-edge latched, 0 = level.
- `clk` in 1: system clock.
- `rst` in 1: reset, synchronous, active-high.
- `s_irq` in 1: machine software interrupt level, `clk` domain.
- `t_irq` in 1: machine timer interrupt level, `clk` domain.
- `e_irq` in N_EXT: external sources, asynchronous.
- `ext_clr` in N_EXT: one-cycle clear pulses for latched edge pending bits.
- `glb_ie` in 1: `mstatus.MIE`.
- `mie` in 32: CSR `mie`; only bits 3, 7 and 11 are used.
- `irq_ack` in 1: CPU has entered the trap for the presented cause.
- `irq_done` in 1: one-cycle pulse on `mret`.
- `mip` out 32: bit 3 = MSIP, bit 7 = MTIP, bit 11 = MEIP, all other bits 0.
- `ext_pend` out N_EXT: per-source pending image, readable by software.
- `irq_req` out 1: interrupt request to the CPU.
- `irq_cause` out 4: cause code, one of 3, 7 or 11.

## Operation
- `s_irq` and `t_irq` are registered once into `msip_r` and `mtip_r`.
- `e_irq` passes through a 2-flop synchroniser into `e_s`, then a third flop `e_d` for edge detect.
- Per source i:
  - Level mode: `ext_pend[i] = e_s[i]`.
  - Edge mode: `ext_pend[i]` is set on `e_s & ~e_d` and cleared by `ext_clr[i]`. Set and clear in the same cycle: set wins.
- `mip[11] = |ext_pend`, `mip[7] = mtip_r`, `mip[3] = msip_r`.
- `en = mip & mie & {32{glb_ie}}`.
- Priority: MEI(11) > MSI(3) > MTI(7). `sel` is the highest-priority set bit of `en`.
- FSM:
  - IDLE: if `en != 0`, latch `sel` into `cause_r` and go to REQ.
  - REQ: `irq_req = 1` and `irq_cause = cause_r`; the cause is frozen even if a higher-priority source appears.
    - `irq_ack` → BUSY.
    - Else, if `en[cause_r] == 0` (source withdrawn or masked) → IDLE, with `irq_req` dropping the next cycle.
  - BUSY: `irq_req = 0`; new requests are suppressed. `irq_done` → IDLE.
- Simultaneous `irq_ack` and withdrawal in REQ: the ack wins (→ BUSY).
- `irq_done` outside BUSY is ignored.
- `rst` mid-operation: the FSM goes to IDLE and all pending, sync and registered state is cleared on the same edge.

## Timing
- Reset values: `mip = 0`, `ext_pend = 0`, `irq_req = 0`, `irq_cause = 0`, FSM = IDLE.
- `t_irq`/`s_irq` sampled high at edge k → `mip` bit set after edge k → `irq_req` high after edge k+1, given enables are set.
- `e_irq` rising before edge k → `ext_pend` set after edge k+2 → `irq_req` after edge k+3.
- Edge mode detects a pulse only if it is held high for at least 2 `clk` periods.
- `irq_ack` at edge m → `irq_req` low after m.
- `irq_done` at edge n → IDLE after n; a still-pending source re-raises `irq_req` after n+1.
- All outputs are registered except `mip` and `ext_pend`, which are flop outputs with no logic after them.

## Structure
- Shared package `quasi_irq_pkg`:
  - Cause constants `CAUSE_MSI = 3`, `CAUSE_MTI = 7`, `CAUSE_MEI = 11`.
  - `mip`/`mie` bit indices.
  - FSM state encoding (IDLE = 0, REQ = 1, BUSY = 2).
- One sub-module: `irq_sync_edge` (per-source 2-flop sync, edge detect, pending latch with `ext_clr`), instantiated N_EXT times via generate.

## Test plan
- **Reset and mask:** hold `rst` for 2 cycles with `t_irq = 1`, `mie = 0` → `irq_req = 0`, `mip = 32'h80`. Then set `mie[7] = 1`, `glb_ie = 1` → `irq_req = 1` after 1 cycle with `irq_cause = 7`.
- **Priority and freeze:** `t_irq = 1` → REQ with cause 7. Assert `e_irq[0]` (level) with `mie = 32'h888` → cause stays 7 until ack. After ack and `irq_done`, the next request has cause 11.
- **Withdrawal:** in REQ with cause 3, drop `s_irq` without ack → `irq_req` low 2 cycles later and the FSM returns to IDLE. Also check ack coincident with withdrawal → BUSY.
- **Edge source:** `EXT_EDGE = 4'b0010`; 3-cycle pulse on `e_irq[1]` → `ext_pend = 4'b0010` held after the pulse ends. `ext_clr = 4'b0010` in the same cycle as a new edge → the bit stays set.
- **Synchroniser latency:** `e_irq[2]` rising mid-cycle → `ext_pend[2]` at edge k+2, `irq_req` at k+3, cause 11.
- **Reset in BUSY:** ack → BUSY, then `rst` → IDLE with `ext_pend = 0`. With `t_irq` still high and enabled, `irq_req` re-asserts 2 cycles after `rst` deasserts.
